// File: rtl/tech_rsreg_pkg.sv
// Shared mode encoding and next-value function for the tech_rsreg register bank.
package tech_rsreg_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_INC  = 3'd4,
    MODE_DEC  = 3'd5,
    MODE_ROTL = 3'd6,
    MODE_ROTR = 3'd7
  } mode_e;

  // Operates on zero-extended MAX_W vectors; 'width' is the live register width.
  function automatic logic [MAX_W-1:0] next_val(
    input logic [MAX_W-1:0] q,
    input logic [MAX_W-1:0] d,
    input logic             si,
    input mode_e            mode,
    input int unsigned      width
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] r;
    mask = {MAX_W{1'b1}} >> (MAX_W - width);
    case (mode)
      MODE_HOLD: r = q;
      MODE_LOAD: r = d;
      MODE_SHL:  r = (q << 1) | MAX_W'(si);
      MODE_SHR:  r = (q >> 1) | (MAX_W'(si) << (width - 1));
      MODE_INC:  r = q + MAX_W'(1);
      MODE_DEC:  r = q - MAX_W'(1);
      MODE_ROTL: r = (q << 1) | MAX_W'(q[width-1]);
      MODE_ROTR: r = (q >> 1) | (MAX_W'(q[0]) << (width - 1));
      default:   r = q;
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/tech_rsreg_bank_cell.sv
// One register bit with enable and synchronous set/clear override (clear wins).
module tech_rsreg_cell #(
  parameter bit NEG_CLK = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic r_i,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = (r_i | set_i) & ~clr_i;
  end

  if (NEG_CLK) begin : g_neg
    always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) q_q <= 1'b0;
      else         q_q <= q_d;
    end
  end else begin : g_pos
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) q_q <= 1'b0;
      else         q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/tech_rsreg_bank.sv
// Multi-mode register bank: load/shift/rotate/inc/dec with per-bit set/clear masks.
// Optional registered parity output enabled by defining TECH_RSREG_PARITY_EN.
module tech_rsreg_bank
  import tech_rsreg_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter bit          NEG_CLK = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  input  logic [WIDTH-1:0] set_mask,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             carry
`ifdef TECH_RSREG_PARITY_EN
  ,
  output logic             par
`endif
);

  mode_e            mode_s;
  logic [WIDTH-1:0] r_d;
  logic             so_q, so_d;
  logic             carry_q, carry_d;

  assign mode_s = mode_e'(mode);
  assign r_d    = WIDTH'(next_val(MAX_W'(q), MAX_W'(d), si, mode_s, WIDTH));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tech_rsreg_cell #(.NEG_CLK(NEG_CLK)) u_cell (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (en),
      .r_i    (r_d[i]),
      .set_i  (set_mask[i]),
      .clr_i  (clr_mask[i]),
      .q_o    (q[i])
    );
  end

  // Wrap flag looks at the pre-mask q, so masks never influence carry.
  always_comb begin
    so_d    = so_q;
    carry_d = carry_q;
    if (en) begin
      carry_d = ((mode_s == MODE_INC) && (q == '1)) ||
                ((mode_s == MODE_DEC) && (q == '0));
      if (mode_s == MODE_SHL) so_d = q[WIDTH-1];
      if (mode_s == MODE_SHR) so_d = q[0];
    end
  end

  if (NEG_CLK) begin : g_neg
    always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
        so_q    <= 1'b0;
        carry_q <= 1'b0;
      end else begin
        so_q    <= so_d;
        carry_q <= carry_d;
      end
    end
  end else begin : g_pos
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        so_q    <= 1'b0;
        carry_q <= 1'b0;
      end else begin
        so_q    <= so_d;
        carry_q <= carry_d;
      end
    end
  end

  assign so    = so_q;
  assign carry = carry_q;

`ifdef TECH_RSREG_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (en) par_d = ^((r_d | set_mask) & ~clr_mask);
  end

  if (NEG_CLK) begin : g_par_neg
    always_ff @(negedge clk or negedge reset) begin
      if (!reset) par_q <= 1'b0;
      else        par_q <= par_d;
    end
  end else begin : g_par_pos
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) par_q <= 1'b0;
      else        par_q <= par_d;
    end
  end

  assign par = par_q;
`endif

endmodule

// File: tb/tb_tech_rsreg_bank.sv
// Directed bench for tech_rsreg_bank: negedge-capturing main DUT plus a posedge twin.
module tb_tech_rsreg_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] d = 8'h00;
  logic       si = 1'b0;
  logic [7:0] set_mask = 8'h00;
  logic [7:0] clr_mask = 8'h00;

  logic [7:0] q, q0;
  logic       so, so0, carry, carry0;
`ifdef TECH_RSREG_PARITY_EN
  logic       par, par0;
`endif

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  tech_rsreg_bank #(.WIDTH(8), .NEG_CLK(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .si(si),
    .set_mask(set_mask), .clr_mask(clr_mask), .q(q), .so(so), .carry(carry)
`ifdef TECH_RSREG_PARITY_EN
    , .par(par)
`endif
  );

  tech_rsreg_bank #(.WIDTH(8), .NEG_CLK(1'b0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .si(si),
    .set_mask(set_mask), .clr_mask(clr_mask), .q(q0), .so(so0), .carry(carry0)
`ifdef TECH_RSREG_PARITY_EN
    , .par(par0)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at negedge+1; drives at negedge+2 and returns at the following negedge+1.
  task automatic op(input logic e, input logic [2:0] m, input logic [7:0] dd,
                    input logic s, input logic [7:0] sm, input logic [7:0] cm);
    #1;
    en = e; mode = m; d = dd; si = s; set_mask = sm; clr_mask = cm;
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset state, asserted asynchronously before any clock edge
    #1 reset = 1'b0;
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_so", {7'd0, so}, 8'h00);
    chk("rst_carry", {7'd0, carry}, 8'h00);
    chk("rst_q0", q0, 8'h00);
`ifdef TECH_RSREG_PARITY_EN
    chk("rst_par", {7'd0, par}, 8'h00);
`endif
    @(negedge clk);
    #1 reset = 1'b1;

    // 1. Async reset mid-INC
    op(1'b1, 3'd1, 8'hB7, 1'b0, 8'h00, 8'h00);
    op(1'b1, 3'd2, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("pre_so", {7'd0, so}, 8'h01);
    op(1'b1, 3'd1, 8'h37, 1'b0, 8'h00, 8'h00);
    chk("pre_q37", q, 8'h37);
    #1 mode = 3'd4;
    #1 reset = 1'b0;
    #1;
    chk("async_q", q, 8'h00);
    chk("async_so", {7'd0, so}, 8'h00);
    chk("async_carry", {7'd0, carry}, 8'h00);
    @(negedge clk);
    #1;
    chk("rst_hold_q", q, 8'h00);
    reset = 1'b1;
    op(1'b1, 3'd1, 8'hA5, 1'b0, 8'h00, 8'h00);
    chk("load_a5", q, 8'hA5);

    // 2. Capture edge selection
    #1;
    mode = 3'd1; d = 8'h3C;
    @(posedge clk);
    #1;
    chk("neg_unchanged_at_pos", q, 8'hA5);
    chk("pos_dut_at_pos", q0, 8'h3C);
    @(negedge clk);
    #1;
    chk("neg_dut_at_neg", q, 8'h3C);

    // 3. Shift / rotate
    op(1'b1, 3'd1, 8'h81, 1'b0, 8'h00, 8'h00);
    op(1'b1, 3'd2, 8'h00, 1'b1, 8'h00, 8'h00);
    chk("shl_q", q, 8'h03);
    chk("shl_so", {7'd0, so}, 8'h01);
    op(1'b1, 3'd3, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("shr_q", q, 8'h01);
    chk("shr_so", {7'd0, so}, 8'h01);
    op(1'b1, 3'd7, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("rotr_q", q, 8'h80);
    chk("rotr_so_hold", {7'd0, so}, 8'h01);
    op(1'b1, 3'd6, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("rotl_q", q, 8'h01);
    op(1'b1, 3'd2, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("shl0_q", q, 8'h02);
    chk("shl0_so", {7'd0, so}, 8'h00);
    chk("pos_dut_track", q0, 8'h02);

    // 4. Increment / decrement wrap
    op(1'b1, 3'd1, 8'hFF, 1'b0, 8'h00, 8'h00);
    op(1'b1, 3'd4, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("inc_wrap_q", q, 8'h00);
    chk("inc_wrap_carry", {7'd0, carry}, 8'h01);
    op(1'b1, 3'd4, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("inc_q", q, 8'h01);
    chk("inc_carry", {7'd0, carry}, 8'h00);
    op(1'b1, 3'd1, 8'h00, 1'b0, 8'h00, 8'h00);
    op(1'b1, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("dec_wrap_q", q, 8'hFF);
    chk("dec_wrap_carry", {7'd0, carry}, 8'h01);
    op(1'b1, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("hold_q", q, 8'hFF);
    chk("hold_carry_clr", {7'd0, carry}, 8'h00);
    op(1'b1, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("dec_q", q, 8'hFE);
    chk("dec_carry", {7'd0, carry}, 8'h00);

    // 5. Masks and enable hold
    op(1'b1, 3'd1, 8'h80, 1'b0, 8'h00, 8'h00);
    op(1'b1, 3'd2, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("mask_pre_q", q, 8'h00);
    op(1'b1, 3'd1, 8'h0F, 1'b0, 8'hF0, 8'h11);
    chk("mask_q", q, 8'hEE);
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 3'(i * 3 + 2), 8'(8'h5A ^ (i * 8'h33)), 1'(i), 8'(8'h0F << i), 8'(8'hF0 >> i));
    end
    chk("en0_q", q, 8'hEE);
    chk("en0_so", {7'd0, so}, 8'h01);
    chk("en0_carry", {7'd0, carry}, 8'h00);
    op(1'b1, 3'd1, 8'hFF, 1'b0, 8'h00, 8'h00);
    op(1'b1, 3'd4, 8'h00, 1'b0, 8'hFF, 8'h00);
    chk("premask_wrap_q", q, 8'hFF);
    chk("premask_wrap_carry", {7'd0, carry}, 8'h01);
    op(1'b0, 3'd4, 8'h00, 1'b0, 8'h00, 8'hFF);
    op(1'b0, 3'd1, 8'h12, 1'b1, 8'h00, 8'hFF);
    chk("en0_carry_hold", {7'd0, carry}, 8'h01);
    chk("en0_q_hold", q, 8'hFF);

`ifdef TECH_RSREG_PARITY_EN
    // 6. Parity
    op(1'b1, 3'd1, 8'h07, 1'b0, 8'h00, 8'h00);
    chk("par_07", {7'd0, par}, 8'h01);
    op(1'b1, 3'd4, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("par_inc_q", q, 8'h08);
    chk("par_08", {7'd0, par}, 8'h01);
    op(1'b1, 3'd4, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("par_inc2_q", q, 8'h09);
    chk("par_09", {7'd0, par}, 8'h00);
    op(1'b1, 3'd1, 8'h00, 1'b0, 8'h07, 8'h01);
    chk("par_mask", {7'd0, par}, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
